// File: rtl/rr_mux_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter_pkg
//   Shared definitions for the round-robin mux arbiter:
//     - arb_state_t   : FSM state encoding (ARB_IDLE / ARB_BUSY)
//     - DEF_NUM_REQ   : default number of requesters
//     - DEF_SEL_BITS  : default select width (2^DEF_SEL_BITS >= DEF_NUM_REQ)
//     - DEF_WIDTH     : default data width per requester
// -----------------------------------------------------------------------------
package rr_mux_arbiter_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_SEL_BITS = 2;
    localparam int DEF_WIDTH    = 32;

endpackage : rr_mux_arbiter_pkg

// File: rtl/mux_param.sv
// -----------------------------------------------------------------------------
// mux_param
//   Parameterized SIZE:1 data multiplexer, WIDTH bits per input.
//   Ports:
//     select : BITS     binary index of the input to forward
//     in     : SIZE*WIDTH packed inputs, input i at [WIDTH*(i+1)-1 : WIDTH*i]
//     out    : WIDTH    selected input
//   A select value >= SIZE drives X so synthesis may treat it as don't-care.
// -----------------------------------------------------------------------------
module mux_param #(
    parameter int BITS  = 2,
    parameter int SIZE  = 4,
    parameter int WIDTH = 32
) (
    input  logic [BITS-1:0]       select,
    input  logic [SIZE*WIDTH-1:0] in,
    output logic [WIDTH-1:0]      out
);

    always_comb begin
        out = 'x;
        for (int i = 0; i < SIZE; i++) begin
            if (select == BITS'(i)) begin
                out = in[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule : mux_param

// File: rtl/rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mux_arbiter
//   Round-robin arbiter sharing one downstream valid/ready channel among
//   NUM_REQ requesters. The grant is held for a whole burst, which ends on an
//   accepted beat carrying last. Every burst is followed by one IDLE cycle.
//   Ports:
//     clk        : clock, rising edge
//     rst        : asynchronous active-low reset
//     req_valid  : NUM_REQ       per-requester beat valid
//     req_last   : NUM_REQ       per-requester last-beat flag
//     req_data   : NUM_REQ*WIDTH packed requester data
//     req_ready  : NUM_REQ       per-requester beat accept (owner only)
//     out_valid  : downstream beat valid
//     out_last   : downstream last flag
//     out_data   : WIDTH downstream data (don't-care while idle)
//     out_ready  : downstream accept
//     grant      : NUM_REQ one-hot owner (registered)
//     grant_sel  : SEL_BITS binary owner index (registered)
//     busy       : high while a burst owns the channel
//   SEL_BITS must satisfy 2^SEL_BITS >= NUM_REQ.
// -----------------------------------------------------------------------------
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int SEL_BITS = DEF_SEL_BITS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_last,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     out_valid,
    output logic                     out_last,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [NUM_REQ-1:0]       grant,
    output logic [SEL_BITS-1:0]      grant_sel,
    output logic                     busy
);

    arb_state_t            state_reg, state_next;
    logic [SEL_BITS-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [SEL_BITS-1:0]   grant_sel_reg, grant_sel_next;
    logic [NUM_REQ-1:0]    grant_reg, grant_next;

    logic [2*NUM_REQ-1:0]  valid_dbl;
    logic [2*NUM_REQ-1:0]  valid_shift;
    logic [NUM_REQ-1:0]    valid_rot;
    logic                  pick_found;
    logic [SEL_BITS-1:0]   pick_idx;

    logic                  owner_valid;
    logic                  owner_last;
    logic                  burst_done;

    // ---------------------------------------------------------------------
    // Round-robin pick: rotate the request vector so rr_ptr lands at bit 0,
    // take the lowest set bit, then add rr_ptr back (mod NUM_REQ).
    // rr_ptr is always < NUM_REQ, so the doubled vector covers every rotation.
    // ---------------------------------------------------------------------
    assign valid_dbl   = {req_valid, req_valid};
    assign valid_shift = valid_dbl >> rr_ptr_reg;
    assign valid_rot   = valid_shift[NUM_REQ-1:0];

    always_comb begin
        int idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && valid_rot[k]) begin
                idx = int'(rr_ptr_reg) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                pick_found = 1'b1;
                pick_idx   = SEL_BITS'(idx);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Owner's control bits, muxed locally from grant_sel.
    // ---------------------------------------------------------------------
    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_sel_reg == SEL_BITS'(i)) begin
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
            end
        end
    end

    assign busy       = (state_reg == ARB_BUSY);
    assign out_valid  = busy & owner_valid;
    assign out_last   = busy & owner_last;
    assign burst_done = out_valid & out_ready & out_last;

    // ---------------------------------------------------------------------
    // FSM next-state
    // ---------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_next     = grant_reg;
        grant_sel_next = grant_sel_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_next     = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    grant_sel_next = pick_idx;
                    state_next     = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (burst_done) begin
                    // Next scan starts just past the finished owner.
                    if (grant_sel_reg == SEL_BITS'(NUM_REQ-1)) begin
                        rr_ptr_next = '0;
                    end else begin
                        rr_ptr_next = grant_sel_reg + 1'b1;
                    end
                    grant_next = '0;
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
                grant_next = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ARB_IDLE;
            rr_ptr_reg    <= '0;
            grant_reg     <= '0;
            grant_sel_reg <= '0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_reg     <= grant_next;
            grant_sel_reg <= grant_sel_next;
        end
    end

    assign grant     = grant_reg;
    assign grant_sel = grant_sel_reg;

    // Only the owner sees the downstream ready; grant is zero while idle.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = busy & grant_reg[gi] & out_ready;
        end
    endgenerate

    mux_param #(
        .BITS  (SEL_BITS),
        .SIZE  (NUM_REQ),
        .WIDTH (WIDTH)
    ) u_data_mux (
        .select (grant_sel_reg),
        .in     (req_data),
        .out    (out_data)
    );

endmodule : rr_mux_arbiter

// File: tb/tb_rr_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mux_arbiter
//   Directed bench for rr_mux_arbiter (4 requesters) plus a 3-requester
//   instance with a 2-bit select that free-runs on all-valid single beats.
// -----------------------------------------------------------------------------
module tb_rr_mux_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_last;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_last;
    logic [31:0]  out_data;
    logic         out_ready;
    logic [3:0]   grant;
    logic [1:0]   grant_sel;
    logic         busy;

    logic [2:0]   v3;
    logic [2:0]   l3;
    logic [95:0]  d3;
    logic [2:0]   ready3;
    logic         ovalid3;
    logic         olast3;
    logic [31:0]  odata3;
    logic [2:0]   grant3;
    logic [1:0]   sel3;
    logic         busy3;

    int total;
    int bad;
    int sel3_viol;
    int sel3_max;
    int grants3;

    logic [31:0] slice [4];

    rr_mux_arbiter #(.NUM_REQ(4), .SEL_BITS(2), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .grant_sel (grant_sel),
        .busy      (busy)
    );

    rr_mux_arbiter #(.NUM_REQ(3), .SEL_BITS(2), .WIDTH(32)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (v3),
        .req_last  (l3),
        .req_data  (d3),
        .req_ready (ready3),
        .out_valid (ovalid3),
        .out_last  (olast3),
        .out_data  (odata3),
        .out_ready (1'b1),
        .grant     (grant3),
        .grant_sel (sel3),
        .busy      (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 3-requester instance monitor
    always @(negedge clk) begin
        if (rst) begin
            if (sel3 == 2'd3) sel3_viol++;
            if (busy3) begin
                if (int'(sel3) > sel3_max) sel3_max = int'(sel3);
                if (ovalid3) grants3++;
            end
        end
    end

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        total = 0; bad = 0; sel3_viol = 0; sel3_max = 0; grants3 = 0;
        slice[0] = 32'hAAAA0000;
        slice[1] = 32'hBBBB0001;
        slice[2] = 32'hCCCC0002;
        slice[3] = 32'hDDDD0003;
        v3 = 3'b111; l3 = 3'b111; d3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};

        // ---- reset with random inputs ----
        rst       = 1'b0;
        req_valid = 4'($urandom);
        req_last  = 4'($urandom);
        req_data  = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'($urandom);
        tick();
        tick();
        check("rst_grant",     64'(grant),     64'h0);
        check("rst_busy",      64'(busy),      64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_last",  64'(out_last),  64'h0);

        // ---- release with requester 0, then backpressure ----
        req_data  = {slice[3], slice[2], slice[1], slice[0]};
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        out_ready = 1'b0;
        rst       = 1'b1;
        tick();
        check("rel_grant",     64'(grant),     64'h1);
        check("rel_grant_sel", 64'(grant_sel), 64'h0);
        check("rel_busy",      64'(busy),      64'h1);
        for (int c = 0; c < 5; c++) begin
            check("bp_req_ready", 64'(req_ready), 64'h0);
            check("bp_out_valid", 64'(out_valid), 64'h1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_accept_ready", 64'(req_ready), 64'h1);
        check("bp_accept_data",  64'(out_data),  64'(slice[0]));
        check("bp_accept_last",  64'(out_last),  64'h1);
        tick();
        check("bp_bubble_busy",  64'(busy),      64'h0);
        check("bp_bubble_grant", 64'(grant),     64'h0);
        check("bp_bubble_valid", 64'(out_valid), 64'h0);

        // ---- requester 1 single beat (rr_ptr 1 -> 2) ----
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        tick();
        check("r1_grant", 64'(grant),    64'h2);
        check("r1_data",  64'(out_data), 64'(slice[1]));
        tick();

        // ---- multi-beat hold: requester 2, three beats; requester 1 waits ----
        req_valid = 4'b0110;
        req_last  = 4'b0000;
        tick();
        for (int b = 0; b < 3; b++) begin
            if (b == 2) req_last = 4'b0100;
            #1;
            check("mb_grant",     64'(grant),     64'h4);
            check("mb_req_ready", 64'(req_ready), 64'h4);
            check("mb_data",      64'(out_data),  64'(slice[2]));
            tick();
        end

        // ---- wrap-around: rr_ptr=3, requesters 0 and 1 ----
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        #1;
        check("wrap_bubble_busy",  64'(busy),      64'h0);
        check("wrap_bubble_ready", 64'(req_ready), 64'h0);
        tick();
        check("wrap_grant",     64'(grant),     64'h1);
        check("wrap_grant_sel", 64'(grant_sel), 64'h0);
        tick();
        check("wrap_release_busy", 64'(busy), 64'h0);
        tick();
        check("next_grant", 64'(grant), 64'h2);

        // ---- owner drops valid: grant held, no timeout ----
        req_valid = 4'b0000;
        #1;
        check("drop_out_valid", 64'(out_valid), 64'h0);
        tick();
        tick();
        check("drop_grant", 64'(grant), 64'h2);
        check("drop_busy",  64'(busy),  64'h1);

        // ---- reset mid-burst (beat 2 of 4) ----
        req_valid = 4'b0010;
        req_last  = 4'b0000;
        #1;
        check("mid_beat1_valid", 64'(out_valid), 64'h1);
        tick();
        rst = 1'b0;
        #1;
        check("midrst_grant",     64'(grant),     64'h0);
        check("midrst_grant_sel", 64'(grant_sel), 64'h0);
        check("midrst_busy",      64'(busy),      64'h0);
        check("midrst_req_ready", 64'(req_ready), 64'h0);
        check("midrst_out_valid", 64'(out_valid), 64'h0);
        tick();

        // ---- simultaneous single-beat requests from rr_ptr=0 ----
        rst       = 1'b1;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("all_grant",     64'(grant),     64'(4'b0001 << order[k]));
            check("all_grant_sel", 64'(grant_sel), 64'(order[k]));
            check("all_data",      64'(out_data),  64'(slice[order[k]]));
            tick();
            check("all_bubble", 64'(busy), 64'h0);
        end

        // ---- 3-requester instance summary ----
        check("n3_sel_never_3", 64'(sel3_viol), 64'h0);
        check("n3_sel_max",     64'(sel3_max),  64'h2);
        check("n3_beats_seen",  64'(grants3 >= 10), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_rr_mux_arbiter
